// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for RV32IM DIV/DIVU/REM/REMU, one quotient bit per clock.
// Define DIV_SPECIAL_BYPASS_EN to send divide-by-zero and signed overflow straight to END.
module div_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      waddr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            we_o,
    output logic [4:0]      waddr_o
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_END} state_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, state_nxt;
    logic            accept;
    logic [CNT_W-1:0] cnt;

    logic [XLEN-1:0] rem, quo, dmag, dividend_raw;
    logic            rem_sel, neg_q, neg_r, div_zero, ovf;

    logic            in_signed, in_zero, in_ovf;
    logic [XLEN:0]   shifted, trial;
    logic            no_borrow;

    function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v);
        // -INT_MIN wraps back to 0x80000000, which is the correct unsigned magnitude
        magnitude = (v < 0) ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [XLEN-1:0] select_result(
        input logic            want_rem,
        input logic [XLEN-1:0] q,
        input logic [XLEN-1:0] r,
        input logic            nq,
        input logic            nr,
        input logic            dz,
        input logic            of,
        input logic [XLEN-1:0] orig_dividend
    );
        if (dz)
            select_result = want_rem ? orig_dividend : '1;
        else if (of)
            select_result = want_rem ? '0 : INT_MIN;
        else if (want_rem)
            select_result = nr ? (~r + 1'b1) : r;
        else
            select_result = nq ? (~q + 1'b1) : q;
    endfunction

    assign in_signed = ~op_i[0];
    assign in_zero   = (divisor_i == '0);
    assign in_ovf    = in_signed && (dividend_i == INT_MIN) && (divisor_i == '1);

    assign shifted   = {rem, quo[XLEN-1]};
    assign no_borrow = (shifted >= {1'b0, dmag});
    assign trial     = shifted - {1'b0, dmag};

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    accept    = 1'b1;
                    state_nxt = S_CALC;
`ifdef DIV_SPECIAL_BYPASS_EN
                    if (in_zero || in_ovf)
                        state_nxt = S_END;
`endif
                end
            end
            S_CALC: begin
                if (flush_i)
                    state_nxt = S_IDLE;
                else if (cnt == CNT_W'(XLEN-1))
                    state_nxt = S_END;
            end
            S_END:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Registered control and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            busy_o   <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
            waddr_o  <= '0;
        end else begin
            busy_o  <= (state_nxt == S_CALC) || (state == S_CALC && state_nxt == S_END);
            valid_o <= (state == S_END) && !flush_i;
            if (accept)
                cnt <= '0;
            else if (state == S_CALC)
                cnt <= cnt + 1'b1;
            if (accept)
                waddr_o <= waddr_i;
            if (state == S_END && !flush_i)
                result_o <= select_result(rem_sel, quo, rem, neg_q, neg_r, div_zero, ovf, dividend_raw);
        end
    end

    // Datapath: operand capture, then one shift/trial-subtract per CALC cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_sel      <= op_i[1];
            neg_q        <= in_signed && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
            neg_r        <= in_signed && dividend_i[XLEN-1];
            div_zero     <= in_zero;
            ovf          <= in_ovf;
            dividend_raw <= dividend_i;
            dmag         <= in_signed ? magnitude(divisor_i) : divisor_i;
            quo          <= in_signed ? magnitude(dividend_i) : dividend_i;
            rem          <= '0;
        end else if (state == S_CALC) begin
            rem <= no_borrow ? trial[XLEN-1:0] : shifted[XLEN-1:0];
            quo <= {quo[XLEN-2:0], no_borrow};
        end
    end

    assign we_o = valid_o;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed vector table, multi-cycle corner sequences
// and randomized operations checked against a plain-arithmetic reference model.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [4:0]  waddr_i;
    logic        flush_i;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic        we_o;
    logic [4:0]  waddr_o;

    int n_cmp = 0;
    int n_bad = 0;

    div_iter #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .waddr_i(waddr_i),
        .flush_i(flush_i), .busy_o(busy_o), .valid_o(valid_o),
        .result_o(result_o), .we_o(we_o), .waddr_o(waddr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // RISC-V M-extension semantics from plain arithmetic
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, sr;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'b00: if (b == 0) model = 32'hFFFF_FFFF;
                   else if (ovf) model = 32'h8000_0000;
                   else begin sr = sa / sb; model = sr; end
            2'b01: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10: if (b == 0) model = a;
                   else if (ovf) model = 32'h0;
                   else begin sr = sa % sb; model = sr; end
            default: model = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic special;
        special = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_SPECIAL_BYPASS_EN
        exp_latency = special ? 1 : 33;
`else
        exp_latency = special ? 33 : 33;
`endif
    endfunction

    // Issue one op, wait for its strobe, and check result, write port, latency and strobe width
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        int lat, elat;
        logic [31:0] res;
        logic [4:0] wa;
        logic we, busy_v, busy1;
        lat = 0; res = '0; wa = '0; we = 1'b0; busy_v = 1'b1; busy1 = 1'b0;
        elat = exp_latency(op, a, b);
        @(negedge clk);
        start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; waddr_i = rd;
        @(posedge clk);
        #1 start_i = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) busy1 = busy_o;
            if (valid_o) begin
                lat = n; res = result_o; wa = waddr_o; we = we_o; busy_v = busy_o;
                break;
            end
        end
        check({tag, " result"}, res, model(op, a, b));
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " we"}, {31'b0, we}, 32'h1);
        check({tag, " waddr"}, {27'b0, wa}, {27'b0, rd});
        check({tag, " busy_in_valid"}, {31'b0, busy_v}, 32'h0);
        if (elat > 1) check({tag, " busy_cycle1"}, {31'b0, busy1}, 32'h1);
        @(posedge clk);
        #1;
        check({tag, " valid_drop"}, {31'b0, valid_o}, 32'h0);
        check({tag, " result_hold"}, result_o, res);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask

    task automatic count_valids(input int cycles, output int cnt, output logic [31:0] last);
        cnt = 0; last = '0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (valid_o) begin cnt++; last = result_o; end
        end
    endtask

    initial begin
        int cnt;
        logic [31:0] last;
        logic [1:0] rop;
        logic [31:0] ra, rb;
        int sel;

        tbl[0]  = '{2'b01, 32'd100,        32'd7,          5'd5,  32'd14};
        tbl[1]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          5'd1,  32'hFFFF_FFFF};
        tbl[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          5'd2,  32'hFFFF_FFFD};
        tbl[3]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd3,  32'h8000_0000};
        tbl[4]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  5'd4,  32'h0};
        tbl[5]  = '{2'b00, 32'd5,          32'd0,          5'd6,  32'hFFFF_FFFF};
        tbl[6]  = '{2'b11, 32'd5,          32'd0,          5'd7,  32'd5};
        tbl[7]  = '{2'b00, 32'hFFFF_FFFB,  32'd0,          5'd8,  32'hFFFF_FFFF};
        tbl[8]  = '{2'b10, 32'hFFFF_FFFB,  32'd0,          5'd9,  32'hFFFF_FFFB};
        tbl[9]  = '{2'b01, 32'd5,          32'd0,          5'd10, 32'hFFFF_FFFF};
        tbl[10] = '{2'b10, 32'd7,          32'hFFFF_FFFE,  5'd11, 32'd1};
        tbl[11] = '{2'b00, 32'd7,          32'hFFFF_FFFE,  5'd12, 32'hFFFF_FFFD};
        tbl[12] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'h0};
        tbl[13] = '{2'b11, 32'hFFFF_FFFF,  32'h10,         5'd0,  32'hF};
        tbl[14] = '{2'b00, 32'h8000_0000,  32'd1,          5'd14, 32'h8000_0000};
        tbl[15] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          5'd31, 32'hFFFF_FFFF};

        rst = 1'b1; start_i = 1'b0; op_i = '0; dividend_i = '0; divisor_i = '0;
        waddr_i = '0; flush_i = 1'b0;
        wait_cycles(3);
        #1;
        check("reset busy", {31'b0, busy_o}, 32'h0);
        check("reset valid", {31'b0, valid_o}, 32'h0);
        check("reset we", {31'b0, we_o}, 32'h0);
        check("reset result", result_o, 32'h0);
        check("reset waddr", {27'b0, waddr_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table sanity against the model, then against the DUT
        for (int i = 0; i < 16; i++) begin
            check($sformatf("tbl%0d model", i), model(tbl[i].op, tbl[i].a, tbl[i].b), tbl[i].exp);
            do_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd);
        end

        // Flush at iteration 10, then a fresh op must come back with full latency
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd3; waddr_i = 5'd7;
        @(posedge clk);
        #1 start_i = 1'b0;
        wait_cycles(10);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        check("flush busy", {31'b0, busy_o}, 32'h0);
        check("flush valid", {31'b0, valid_o}, 32'h0);
        do_op("after_flush", 2'b01, 32'd9, 32'd3, 5'd3);

        // Reset at iteration 20 clears everything
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd3; waddr_i = 5'd7;
        @(posedge clk);
        #1 start_i = 1'b0;
        wait_cycles(20);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst busy", {31'b0, busy_o}, 32'h0);
        check("midrst valid", {31'b0, valid_o}, 32'h0);
        check("midrst we", {31'b0, we_o}, 32'h0);
        check("midrst result", result_o, 32'h0);
        check("midrst waddr", {27'b0, waddr_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        count_valids(40, cnt, last);
        check("midrst no_result", 32'(cnt), 32'h0);

        // Start pulse while busy must not produce a second result
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd3; waddr_i = 5'd7;
        @(posedge clk);
        #1 start_i = 1'b0;
        wait_cycles(5);
        @(negedge clk);
        start_i = 1'b1; dividend_i = 32'd50; divisor_i = 32'd5; waddr_i = 5'd9;
        @(negedge clk);
        start_i = 1'b0;
        count_valids(70, cnt, last);
        check("busy_start count", 32'(cnt), 32'h1);
        check("busy_start result", last, 32'd333);
        check("busy_start waddr", {27'b0, waddr_o}, 32'd7);

        // start together with flush in IDLE is dropped
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1; op_i = 2'b01; dividend_i = 32'd10; divisor_i = 32'd2;
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        check("idle_flush busy", {31'b0, busy_o}, 32'h0);
        count_valids(40, cnt, last);
        check("idle_flush no_result", 32'(cnt), 32'h0);

        // Randomized ops against the reference model
        for (int i = 0; i < 120; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            sel = $urandom_range(0, 15);
            case (sel)
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                3:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                4:       begin ra = 32'($urandom_range(0, 200)); rb = 32'($urandom_range(1, 20)); end
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            do_op($sformatf("rnd%0d", i), rop, ra, rb, 5'($urandom_range(0, 31)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative 32-bit divider for the RV32IM M-extension DIV/DIVU/REM/REMU instructions.
- Sits directly downstream of the register file. It consumes the rs1/rs2 read data latched by the execute stage.
- Its result feeds straight back into the register-file write port (we/waddr/wdata).
- Radix-2 restoring algorithm: one quotient bit per clock.

Parameters:
- XLEN, 32, operand/result width (only 32 supported)
- CNT_W, 6, iteration counter width (must hold 0..XLEN)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- start_i  input  1  request a divide; sampled only in IDLE
- op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend_i  input  32  rs1 data
- divisor_i  input  32  rs2 data
- waddr_i  input  5  destination register rd
- flush_i  input  1  abort current operation (branch/exception kill)
- busy_o  output  1  operation in progress; stall request to pipeline
- valid_o  output  1  one-cycle result strobe
- result_o  output  32  quotient or remainder
- we_o  output  1  register write enable (equals valid_o)
- waddr_o  output  5  rd captured at start

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, counter=0, busy_o=0, valid_o=0, we_o=0, result_o=0, waddr_o=0. Reset overrides every other input, including mid-operation; the partial result is discarded.
- All outputs are registered.
- States:
  - IDLE: if start_i=1 and flush_i=0, latch op_i, waddr_i, sign flags and operand magnitudes. Next state is CALC (or END per the Optional Feature). busy_o=1 from the next cycle.
  - CALC: 64-bit shift register {rem,quo}. Each cycle: shift left 1, trial-subtract |divisor| from the upper 32 bits. If no borrow, keep the difference and set quo bit0=1. After 32 iterations (counter 0..31), go to END.
  - END: apply sign fixup and select the result, drive valid_o=we_o=1 for exactly one cycle, set busy_o=0, return to IDLE.
- Latency (normal path): valid_o is high in the 33rd cycle after the edge that accepted start_i. busy_o is high for cycles 1..32 after acceptance and low in the valid cycle.
- Signed ops (DIV/REM):
  - The divide runs on absolute values; |-2^31| is treated as unsigned 0x80000000.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Unsigned ops: no fixup.
- Divide by zero: quotient=0xFFFFFFFF for both DIV and DIVU; remainder=dividend (unmodified, original sign).
- Signed overflow (DIV/REM of 0x80000000 by 0xFFFFFFFF): quotient=0x80000000, remainder=0.
- start_i while busy_o=1 or in END: ignored. The upstream must hold the instruction while busy_o=1.
- flush_i=1 in CALC or END: state goes to IDLE next cycle, busy_o=0, and no valid_o/we_o is produced for the flushed op.
- flush_i=1 together with start_i in IDLE: flush wins and the request is dropped.
- waddr_o=0: we_o is still asserted. The register file ignores writes to x0.
- result_o holds its last value outside the valid cycle. Consumers must qualify it with valid_o.

Optional Feature:
- Macro DIV_SPECIAL_BYPASS_EN.
- Defined: divide-by-zero and signed overflow are detected in IDLE at acceptance and go directly to END. valid_o fires 1 cycle after acceptance and busy_o stays 0 for that op.
- Undefined: special cases run the full 32-iteration CALC path, with the same latency as normal ops. END substitutes the architecturally defined results above. Results are identical either way; only latency differs.

Test Plan:
- DIVU 100/7 (rd=5) -> after 33 cycles, valid_o=1 for one cycle with result_o=14, waddr_o=5, we_o=1.
- REM -7 (0xFFFFFFF9) by 2 -> result_o=0xFFFFFFFF (-1).
- DIV -7 by 2 -> result_o=0xFFFFFFFD (-3).
- DIV 0x80000000 by 0xFFFFFFFF -> result_o=0x80000000; REM with the same operands -> 0. Latency is 1 cycle with DIV_SPECIAL_BYPASS_EN defined, 33 without.
- DIV 5 by 0 -> 0xFFFFFFFF; REMU 5 by 0 -> 5; DIV -5 by 0 -> 0xFFFFFFFF; REM -5 by 0 -> 0xFFFFFFFB.
- Start DIVU 1000/3, assert flush_i at iteration 10 -> busy_o=0 next cycle and no valid_o. A new DIVU 9/3 started immediately after returns 3 with full latency.
- Start DIVU 1000/3, assert rst at iteration 20 -> all outputs 0 next cycle, state IDLE. A start_i pulse while busy_o=1 produces no second result.
